task_queue_arbiter: RTL

//   Upstream stage of the scheduler's 4-bit task mux. Buffers task IDs from two sources in
//   two small FIFOs and presents the two queue heads on q0_head/q1_head (to mux in0/in1).

---
 rtl/task_queue_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/task_queue_arbiter.sv
// Two-source task queue arbiter: two circular FIFOs feeding a 2:1 task mux, one dispatch per handshake.
// Optional SCHED_RR_EN selects round-robin grant; default build is fixed priority (queue 0 first).
module task_queue_arbiter #(
    parameter int TW    = 4,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push0,
    input  logic [TW-1:0] task0,
    input  logic          push1,
    input  logic [TW-1:0] task1,
    output logic          full0,
    output logic          full1,
    output logic [CW-1:0] count0,
    output logic [CW-1:0] count1,
    output logic [TW-1:0] q0_head,
    output logic [TW-1:0] q1_head,
    output logic          sel,
    output logic          disp_valid,
    input  logic          disp_ready,
    output logic          ovf
);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t        state, state_n;
    logic [TW-1:0] mem    [2][DEPTH];
    logic [AW-1:0] rd_ptr [2];
    logic [AW-1:0] wr_ptr [2];
    logic [CW-1:0] cnt    [2];
    logic [TW-1:0] head   [2];
    logic [TW-1:0] head_n [2];
    logic [TW-1:0] din    [2];
    logic [1:0]    push, pop, acc;
    logic          hs, grant;
`ifdef SCHED_RR_EN
    logic          last_grant;
`endif

    assign push    = {push1, push0};
    assign din[0]  = task0;
    assign din[1]  = task1;
    assign count0  = cnt[0];
    assign count1  = cnt[1];
    assign full0   = (cnt[0] == CW'(DEPTH));
    assign full1   = (cnt[1] == CW'(DEPTH));
    assign q0_head = head[0];
    assign q1_head = head[1];

    // Push admission and next registered head (oldest entry, 0 when empty)
    always_comb begin
        acc = '0;
        for (int q = 0; q < 2; q++) begin
            acc[q]    = push[q] && ((cnt[q] != CW'(DEPTH)) || pop[q]);
            head_n[q] = head[q];
            if (pop[q]) begin
                if (cnt[q] > CW'(1)) head_n[q] = mem[q][rd_ptr[q] + AW'(1)];
                else                 head_n[q] = acc[q] ? din[q] : '0;
            end else if (cnt[q] == '0) begin
                head_n[q] = acc[q] ? din[q] : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int q = 0; q < 2; q++) begin
                rd_ptr[q] <= '0;
                wr_ptr[q] <= '0;
                cnt[q]    <= '0;
                head[q]   <= '0;
            end
            ovf <= 1'b0;
        end else begin
            for (int q = 0; q < 2; q++) begin
                if (acc[q]) wr_ptr[q] <= wr_ptr[q] + AW'(1);
                if (pop[q]) rd_ptr[q] <= rd_ptr[q] + AW'(1);
                if (acc[q] && !pop[q])      cnt[q] <= cnt[q] + CW'(1);
                else if (!acc[q] && pop[q]) cnt[q] <= cnt[q] - CW'(1);
                head[q] <= head_n[q];
                if (push[q] && !acc[q]) ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int q = 0; q < 2; q++)
            if (acc[q]) mem[q][wr_ptr[q]] <= din[q];
    end

    always_comb begin
`ifdef SCHED_RR_EN
        if (cnt[0] != '0 && cnt[1] != '0) grant = ~last_grant;
        else                              grant = (cnt[0] == '0);
`else
        grant = (cnt[0] == '0);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (cnt[0] != '0 || cnt[1] != '0) state_n = OFFER;
            OFFER:   if (disp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        disp_valid = (state == OFFER);
        hs         = disp_valid && disp_ready;
        pop        = {hs && sel, hs && !sel};
    end

    // sel is latched on IDLE->OFFER so late pushes cannot disturb the offer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel <= 1'b0;
`ifdef SCHED_RR_EN
            last_grant <= 1'b1;
`endif
        end else begin
            if (state == IDLE && state_n == OFFER) sel <= grant;
`ifdef SCHED_RR_EN
            if (hs) last_grant <= sel;
`endif
        end
    end

endmodule
